stream_demux4: RTL



---
 rtl/stream_pkg.sv | 15 +
 rtl/stream_slice1.sv | 42 ++++
 rtl/stream_demux4.sv | 90 +++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// Shared definitions for the stream_demux4 slice: port count, select width,
// FSM state type and default widths.
package stream_pkg;

    localparam int NPORTS = 4;
    localparam int SEL_W  = 2;
    localparam int DEF_DW = 2;
    localparam int DEF_CW = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        ROUTE = 1'b1
    } demux_state_t;

endpackage

// File: rtl/stream_slice1.sv
// One-entry valid/ready register slice. A load always wins: loading while the
// current entry drains replaces the contents and keeps valid high.
module stream_slice1
    import stream_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    input  logic          i_last,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_last
);

    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          r_last;

    // Load, drain or hold the single entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule

// File: rtl/stream_demux4.sv
// 1-to-4 packet stream demultiplexer. The destination is taken from in_sel on
// the first beat of a packet and locked until the last beat. Each output port
// has its own one-entry slice so ports drain independently.
// Optional: define STREAM_DEMUX4_STATS_EN for per-port saturating beat
// counters (stats_clr / beat_cnt ports).
module stream_demux4
    import stream_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int CW = DEF_CW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic [DW-1:0]        in_data,
    input  logic                 in_last,
    output logic [NPORTS-1:0]    out_valid,
    input  logic [NPORTS-1:0]    out_ready,
    output logic [NPORTS*DW-1:0] out_data,
    output logic [NPORTS-1:0]    out_last,
    output logic                 busy,
    output logic [SEL_W-1:0]     cur_sel
`ifdef STREAM_DEMUX4_STATS_EN
   ,input  logic                 stats_clr,
    output logic [NPORTS*CW-1:0] beat_cnt
`endif
);

    demux_state_t      r_state;
    logic [SEL_W-1:0]  r_cur_sel;
    logic [SEL_W-1:0]  w_target;
    logic              w_accept;
    logic [NPORTS-1:0] w_load;

    // Target follows in_sel only between packets; mid-packet it is locked.
    assign w_target = (r_state == IDLE) ? in_sel : r_cur_sel;
    assign in_ready = !out_valid[w_target] || out_ready[w_target];
    assign w_accept = in_valid && in_ready;
    assign busy     = (r_state == ROUTE);
    assign cur_sel  = r_cur_sel;

    // Packet framing FSM: lock the destination on the first beat, release on last.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cur_sel <= '0;
        end else if (w_accept) begin
            if (r_state == IDLE) begin
                r_cur_sel <= in_sel;
                r_state   <= in_last ? IDLE : ROUTE;
            end else if (in_last) begin
                r_state <= IDLE;
            end
        end
    end

    for (genvar g = 0; g < NPORTS; g++) begin : g_port
        assign w_load[g] = w_accept && (w_target == SEL_W'(g));

        stream_slice1 #(.DW(DW)) u_slice (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load[g]),
            .i_data  (in_data),
            .i_last  (in_last),
            .i_ready (out_ready[g]),
            .o_valid (out_valid[g]),
            .o_data  (out_data[g*DW +: DW]),
            .o_last  (out_last[g])
        );

`ifdef STREAM_DEMUX4_STATS_EN
        logic [CW-1:0] r_cnt;

        // Count delivered beats, saturating; clear wins over an increment.
        always_ff @(posedge clk) begin
            if (rst || stats_clr) begin
                r_cnt <= '0;
            end else if (out_valid[g] && out_ready[g] && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end

        assign beat_cnt[g*CW +: CW] = r_cnt;
`endif
    end

endmodule
